dot_acc_requant: RTL and testbench

//  Consumes the 32-bit sign-extended 4-lane dot products from the MAC stage and

---
 rtl/dot_acc_requant.sv | 131 +++++++++++++
 tb/tb_dot_acc_requant.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dot_acc_requant.sv
// Group accumulator with bias seeding, rounding right-shift requantization and
// output saturation, feeding a single-entry valid/ready result register.
//
// state | meaning
// IDLE  | no group open; next accepted beat is the first of a group
// ACCUM | group open; acc holds the saturated running sum
module dot_acc_requant #(
    parameter int IN_WIDTH    = 32,
    parameter int ACC_WIDTH   = 32,
    parameter int OUT_WIDTH   = 16,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_WIDTH-1:0]    in_data,
    input  logic                   in_last,
    input  logic [ACC_WIDTH-1:0]   cfg_bias,
    input  logic [SHIFT_WIDTH-1:0] cfg_shift,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   out_sat,
    output logic                   busy
);

    // One guard bit above the accumulator keeps sums and rounding overflow-free.
    localparam int SW = ACC_WIDTH + 1;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX   = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN   = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [SW-1:0]        OUT_MAX_X = {{(SW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [SW-1:0]        OUT_MIN_X = {{(SW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [OUT_WIDTH-1:0] OUT_MAX   = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] OUT_MIN   = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t               state;
    logic [ACC_WIDTH-1:0] acc;
    logic                 acc_sat;

    logic                 accept;
    logic                 finish;
    logic [ACC_WIDTH-1:0] base;
    logic [SW-1:0]        base_x;
    logic [SW-1:0]        in_x;
    logic [SW-1:0]        sum_x;
    logic                 sum_ovf;
    logic [ACC_WIDTH-1:0] sum_sat;
    logic [SW-1:0]        rnd;
    logic [SW-1:0]        rsum;
    logic [SW-1:0]        rq;
    logic                 clip_hi;
    logic                 clip_lo;
    logic [OUT_WIDTH-1:0] q_data;
    logic                 q_sat;

    // Input may only be taken when the result register is free or being drained.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign finish   = accept && in_last;
    assign busy     = (state == ACCUM);

    // Saturating add of the incoming beat onto the bias (first beat) or running sum.
    always_comb begin
        base    = (state == IDLE) ? cfg_bias : acc;
        base_x  = {base[ACC_WIDTH-1], base};
        in_x    = {{(SW-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
        sum_x   = base_x + in_x;
        sum_ovf = sum_x[SW-1] ^ sum_x[SW-2];
        sum_sat = sum_x[ACC_WIDTH-1:0];
        if (sum_ovf) begin
            sum_sat = sum_x[SW-1] ? ACC_MIN : ACC_MAX;
        end
    end

    // Round-half-up arithmetic shift of the final sum, then clamp to the output range.
    always_comb begin
        rnd = '0;
        if (cfg_shift != '0) begin
            rnd = SW'(1) << (cfg_shift - SHIFT_WIDTH'(1));
        end
        rsum    = {sum_sat[ACC_WIDTH-1], sum_sat} + rnd;
        rq      = $signed(rsum) >>> cfg_shift;
        clip_hi = $signed(rq) > $signed(OUT_MAX_X);
        clip_lo = $signed(rq) < $signed(OUT_MIN_X);
        q_data  = rq[OUT_WIDTH-1:0];
        if (clip_hi) begin
            q_data = OUT_MAX;
        end else if (clip_lo) begin
            q_data = OUT_MIN;
        end
        q_sat = acc_sat | sum_ovf | clip_hi | clip_lo;
    end

    // Group sequencing and sticky accumulator saturation flag.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            acc     <= '0;
            acc_sat <= 1'b0;
        end else if (accept) begin
            acc <= sum_sat;
            if (in_last) begin
                state   <= IDLE;
                acc_sat <= 1'b0;
            end else begin
                state   <= ACCUM;
                acc_sat <= acc_sat | sum_ovf;
            end
        end
    end

    // Result register; a finish in the same cycle as a pop simply overwrites it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (finish) begin
            out_valid <= 1'b1;
            out_data  <= q_data;
            out_sat   <= q_sat;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dot_acc_requant.sv
// Directed bench for dot_acc_requant with an arithmetic group model and a
// result scoreboard checked every cycle.
module tb_dot_acc_requant;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic [31:0] cfg_bias = '0;
    logic [4:0]  cfg_shift = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_sat;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int stall_cycles = 0;

    // model state
    longint      m_acc = 0;
    bit          m_sat = 0;
    bit          in_group = 0;
    logic [16:0] exp_q[$];
    logic [16:0] obs_q[$];
    logic [16:0] lit [0:10];

    dot_acc_requant dut (
        .clock(clock), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .cfg_bias(cfg_bias), .cfg_shift(cfg_shift),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference for one accepted beat.
    task automatic model_beat(input longint d, input bit last, input longint b, input int k);
        longint t;
        longint r;
        bit     clip;
        t = (in_group ? m_acc : b) + d;
        if (!in_group) m_sat = 0;
        if (t > 64'sd2147483647) begin
            t = 64'sd2147483647; m_sat = 1;
        end else if (t < -64'sd2147483648) begin
            t = -64'sd2147483648; m_sat = 1;
        end
        m_acc = t;
        if (last) begin
            r = (t + ((k != 0) ? (64'sd1 << (k - 1)) : 64'sd0)) >>> k;
            clip = 0;
            if (r > 32767) begin r = 32767; clip = 1; end
            else if (r < -32768) begin r = -32768; clip = 1; end
            exp_q.push_back({m_sat | clip, r[15:0]});
            in_group = 0;
            m_sat = 0;
        end else begin
            in_group = 1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send(input logic signed [31:0] d, input bit last,
                        input logic signed [31:0] b, input int k);
        bit rdy;
        bit done;
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = last;
        cfg_bias  = b;
        cfg_shift = k[4:0];
        done = 0;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clock);
            rdy = in_ready;
            @(posedge clock);
            if (rdy) begin
                model_beat(longint'(d), last, longint'(b), k);
                done = 1;
            end
            #1;
        end
        if (!done) begin
            errors++; checks++;
            $display("FAIL send_timeout: beat %0d never accepted", d);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Per-cycle scoreboard compare, away from the active edge.
    always @(negedge clock) begin
        if (resetn) begin
            chk("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() > 0});
            chk("in_ready", {31'b0, in_ready}, {31'b0, (exp_q.size() == 0) || out_ready});
            chk("busy", {31'b0, busy}, {31'b0, in_group});
            if (in_valid && !in_ready) stall_cycles++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL unexpected_result: got %0h expected none", out_data);
                end else begin
                    chk("result", {15'b0, out_sat, out_data}, {15'b0, exp_q[0]});
                    void'(exp_q.pop_front());
                end
                obs_q.push_back({out_sat, out_data});
            end
        end
    end

    initial begin
        lit[0] = 17'h00014; lit[1] = 17'h00002; lit[2] = 17'h0FFFE; lit[3] = 17'h17FFF;
        lit[4] = 17'h00001; lit[5] = 17'h17FFF; lit[6] = 17'h00001; lit[7] = 17'h00002;
        lit[8] = 17'h00003; lit[9] = 17'h00004; lit[10] = 17'h00003;

        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", {16'b0, out_data}, 32'd0);
        chk("rst_out_sat", {31'b0, out_sat}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
        idle(1);

        // 1: bias 10, 5+7-2 -> 20
        send(5, 0, 10, 0);
        send(7, 0, 99, 0);
        send(-2, 1, 99, 0);
        idle(2);

        // 2: rounding shifts
        send(5, 0, 0, 9);
        send(1, 1, 0, 2);
        idle(1);
        send(-7, 0, 0, 9);
        send(0, 1, 0, 2);
        idle(2);

        // 3: output clip, then a clean one-beat group
        send(30000, 0, 0, 0);
        send(10000, 1, 0, 0);
        idle(1);
        send(1, 1, 0, 0);
        idle(2);

        // 4: accumulator clamp then output clip
        send(32'h100, 0, 32'h7FFFFFF0, 0);
        send(-32'sh100, 1, 0, 16);
        idle(2);

        // 5: back-to-back one-beat groups with downstream stall
        stall_cycles = 0;
        fork
            begin
                send(1, 1, 0, 0);
                send(2, 1, 0, 0);
                send(3, 1, 0, 0);
                send(4, 1, 0, 0);
                idle(1);
            end
            begin
                @(posedge clock); #1;
                out_ready = 1'b0;
                repeat (2) @(posedge clock);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(3);
        checks++;
        if (stall_cycles == 0) begin
            errors++;
            $display("FAIL stall_seen: got 0 stalled cycles expected >0");
        end

        // 6: reset in the middle of a group
        send(100, 0, 50, 0);
        send(200, 0, 0, 0);
        in_valid = 1'b0;
        resetn = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_out_data", {16'b0, out_data}, 32'd0);
        chk("mid_rst_out_sat", {31'b0, out_sat}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        exp_q.delete();
        in_group = 0;
        m_sat = 0;
        @(posedge clock); #1;
        resetn = 1'b1;
        idle(1);
        send(3, 1, 0, 0);
        idle(3);

        chk("drained", exp_q.size(), 32'd0);
        chk("obs_count", obs_q.size(), 32'd11);
        for (int i = 0; i < 11; i++) begin
            if (i < obs_q.size()) chk($sformatf("literal_%0d", i), {15'b0, obs_q[i]}, {15'b0, lit[i]});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
